// File: rtl/activation_pwl_pipe_if.sv
// Handshake bundle for the piecewise-linear activation pipe: input beat, output beat and beat counter.
// The slave modport is the pipe side; the master modport is the producer/consumer side.
interface activation_pwl_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [1:0]                    in_mode;
  logic [LANES*DATA_WIDTH-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic [LANES-1:0]              out_sat;
  logic [1:0]                    out_mode;
  logic [CNT_WIDTH-1:0]          beat_count;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_mode, beat_count
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_mode, beat_count
  );
endinterface

// File: rtl/activation_pwl_pipe.sv
// Multi-lane hard sigmoid / hard tanh / PLAN sigmoid / identity; 2 register stages, 1 beat/cycle.
// Whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid | out_ready.
module activation_pwl_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  activation_pwl_pipe_if.slave bus
);

  localparam int W1 = DATA_WIDTH + 1;
  localparam int ONE_I = 2 ** FRACT_WIDTH;

  localparam logic signed [W1-1:0] K_ONE  = W1'(ONE_I);
  localparam logic signed [W1-1:0] K_NONE = -K_ONE;
  localparam logic signed [W1-1:0] K_TWO  = W1'(2 * ONE_I);
  localparam logic signed [W1-1:0] K_NTWO = -K_TWO;
  localparam logic signed [W1-1:0] K_HALF = W1'(ONE_I / 2);
  localparam logic signed [W1-1:0] K_C1   = W1'((5 * ONE_I) / 8);
  localparam logic signed [W1-1:0] K_C2   = W1'((27 * ONE_I) / 32);
  localparam logic signed [W1-1:0] K_T1   = W1'((19 * ONE_I) / 8);
  localparam logic signed [W1-1:0] K_FIVE = W1'(5 * ONE_I);
  localparam logic signed [W1-1:0] K_MAXP = W1'((2 ** (DATA_WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    MODE_HSIG  = 2'd0,
    MODE_HTANH = 2'd1,
    MODE_PLAN  = 2'd2,
    MODE_IDENT = 2'd3
  } mode_e;

  // Clamp modes use MID/HI/LO; PLAN uses the segment index 0..3 directly.
  localparam logic [1:0] SEG_MID = 2'd0;
  localparam logic [1:0] SEG_HI  = 2'd1;
  localparam logic [1:0] SEG_LO  = 2'd2;

  logic                                  en;

  logic                                  v1_q, v1_d;
  logic [1:0]                            mode1_q, mode1_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]      x1_q, x1_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]      a1_q, a1_d;
  logic [LANES-1:0]                      sign1_q, sign1_d;
  logic [LANES-1:0][1:0]                 seg1_q, seg1_d;

  logic                                  out_valid_q, out_valid_d;
  logic [LANES*DATA_WIDTH-1:0]           out_data_q, out_data_d;
  logic [LANES-1:0]                      out_sat_q, out_sat_d;
  logic [1:0]                            out_mode_q, out_mode_d;
  logic [CNT_WIDTH-1:0]                  beat_count_q, beat_count_d;

  logic [LANES-1:0][DATA_WIDTH-1:0]      a_in;
  logic [LANES-1:0]                      sign_in;
  logic [LANES-1:0][1:0]                 seg_in;
  logic [LANES-1:0][DATA_WIDTH-1:0]      y_st2;
  logic [LANES-1:0]                      sat_st2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [W1-1:0] xe, xn, ae;
    logic signed [W1-1:0] xe2, ae2, f2, y2;
    logic [1:0]           seg_l;
    logic                 sat2;

    always_comb begin : st1_lane
      xe    = {bus.in_data[i*DATA_WIDTH+DATA_WIDTH-1], bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
      xn    = -xe;
      // |most-negative| does not fit the word, so it saturates to max positive.
      ae    = xe[W1-1] ? ((xn > K_MAXP) ? K_MAXP : xn) : xe;
      seg_l = SEG_MID;
      case (mode_e'(bus.in_mode))
        MODE_HSIG: begin
          if (xe > K_TWO)       seg_l = SEG_HI;
          else if (xe < K_NTWO) seg_l = SEG_LO;
        end
        MODE_HTANH: begin
          if (xe > K_ONE)       seg_l = SEG_HI;
          else if (xe < K_NONE) seg_l = SEG_LO;
        end
        MODE_PLAN: begin
          if (ae < K_ONE)       seg_l = 2'd0;
          else if (ae < K_T1)   seg_l = 2'd1;
          else if (ae < K_FIVE) seg_l = 2'd2;
          else                  seg_l = 2'd3;
        end
        default: seg_l = SEG_MID;
      endcase
    end

    assign a_in[i]    = ae[DATA_WIDTH-1:0];
    assign sign_in[i] = bus.in_data[i*DATA_WIDTH+DATA_WIDTH-1];
    assign seg_in[i]  = seg_l;

    always_comb begin : st2_lane
      xe2  = {x1_q[i][DATA_WIDTH-1], x1_q[i]};
      ae2  = {1'b0, a1_q[i]};
      f2   = K_ONE;
      y2   = xe2;
      sat2 = 1'b0;
      case (seg1_q[i])
        2'd0:    f2 = (ae2 >>> 2) + K_HALF;
        2'd1:    f2 = (ae2 >>> 3) + K_C1;
        2'd2:    f2 = (ae2 >>> 5) + K_C2;
        default: f2 = K_ONE;
      endcase
      case (mode_e'(mode1_q))
        MODE_HSIG: begin
          if (seg1_q[i] == SEG_HI) begin
            y2   = K_ONE;
            sat2 = 1'b1;
          end else if (seg1_q[i] == SEG_LO) begin
            y2   = '0;
            sat2 = 1'b1;
          end else begin
            y2   = (xe2 + K_TWO) >>> 2;
          end
        end
        MODE_HTANH: begin
          if (seg1_q[i] == SEG_HI) begin
            y2   = K_ONE;
            sat2 = 1'b1;
          end else if (seg1_q[i] == SEG_LO) begin
            y2   = K_NONE;
            sat2 = 1'b1;
          end
        end
        MODE_PLAN: begin
          // Negative inputs use the sigmoid symmetry f(-a) = 1 - f(a).
          y2   = sign1_q[i] ? (K_ONE - f2) : f2;
          sat2 = (seg1_q[i] == 2'd3);
        end
        default: y2 = xe2;
      endcase
    end

    assign y_st2[i]   = y2[DATA_WIDTH-1:0];
    assign sat_st2[i] = sat2;
  end

  always_comb begin
    en           = !out_valid_q || bus.out_ready;
    v1_d         = v1_q;
    mode1_d      = mode1_q;
    x1_d         = x1_q;
    a1_d         = a1_q;
    sign1_d      = sign1_q;
    seg1_d       = seg1_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    out_mode_d   = out_mode_q;
    beat_count_d = beat_count_q + CNT_WIDTH'(out_valid_q && bus.out_ready);
    if (en) begin
      v1_d        = bus.in_valid;
      mode1_d     = bus.in_mode;
      x1_d        = bus.in_data;
      a1_d        = a_in;
      sign1_d     = sign_in;
      seg1_d      = seg_in;
      out_valid_d = v1_q;
      out_data_d  = y_st2;
      out_sat_d   = sat_st2;
      out_mode_d  = mode1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      mode1_q      <= '0;
      x1_q         <= '0;
      a1_q         <= '0;
      sign1_q      <= '0;
      seg1_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= '0;
      out_mode_q   <= '0;
      beat_count_q <= '0;
    end else begin
      v1_q         <= v1_d;
      mode1_q      <= mode1_d;
      x1_q         <= x1_d;
      a1_q         <= a1_d;
      sign1_q      <= sign1_d;
      seg1_q       <= seg1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      out_mode_q   <= out_mode_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.beat_count = beat_count_q;

endmodule
